ama_riscv_mem_arbiter: RTL and testbench
========================================

# ama_riscv_mem_arbiter

Two-requester arbiter sharing the single main-memory port between the icache and the dcache line-fill engines. A requester that wins owns the memory port for one full cache-line burst of BEATS request/response beats, and responses are steered back to it only. Ties are broken round-robin. Sits between the cache miss handlers and the main-memory model/controller.

## Interface
- ADDR_W, default MEM_ADDR_BUS: memory-bus beat address width.
- DATA_W, default MEM_DATA_BUS: memory-bus data width (one beat).
- BEATS, default MEM_TRANSFERS_PER_CL: beats per cache line; power of 2, >= 1.
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- req_ic  rv_if.RX  ADDR_W  icache beat address request.
- rsp_ic  rv_if.TX  DATA_W  icache beat data response.
- req_dc  rv_if.RX  ADDR_W  dcache beat address request.
- rsp_dc  rv_if.TX  DATA_W  dcache beat data response.
- req_mem  rv_if.TX  ADDR_W  address to main memory.
- rsp_mem  rv_if.RX  DATA_W  data from main memory.
- grant_ic, grant_dc  out  1  current burst owner (one-hot or both 0).
- err_unexp_rsp  out  1  sticky: rsp_mem.valid seen with no outstanding request.

## Operation
- States (arb_state_t): ARB_IDLE, ARB_IC, ARB_DC. Reset state ARB_IDLE.
- ARB_IDLE: if exactly one req_*.valid, that requester wins; if both, winner is the one not granted last (rr_last). rr_last resets to DC, so icache wins the first tie.
- Grant is combinational in the winning cycle: the winner's first beat is forwarded to req_mem in the same cycle; state moves to ARB_IC/ARB_DC next edge; rr_last updated to the winner.
- Owner states: req_mem.valid = owner req.valid && req_cnt < BEATS; req_mem.data = owner req.data; owner req.ready = req_mem.ready && req_cnt < BEATS. Non-owner req.ready = 0 always; the non-owner holds valid/data until accepted.
- Responses: owner rsp.valid = rsp_mem.valid, rsp.data = rsp_mem.data, rsp_mem.ready = owner rsp.ready. Non-owner rsp.valid = 0, rsp.data = 0.
- req_cnt counts accepted request beats (req_mem.valid && req_mem.ready); rsp_cnt counts accepted response beats. Both are $clog2(BEATS)+1 bits wide and cleared on burst end.
- Burst end: the accepted response beat with rsp_cnt == BEATS-1 -> next state ARB_IDLE, counters cleared. One idle cycle is always inserted between bursts.
- Unexpected response, i.e. rsp_mem.valid in ARB_IDLE or rsp_cnt == req_cnt: rsp_mem.ready = 1 (drain), data dropped, err_unexp_rsp set until rst.

## Timing
- Reset values: all valid/ready outputs 0, all data outputs 0, grant_* 0, err_unexp_rsp 0, counters 0.
- Arbitration adds zero cycles on the request path (combinational) and zero cycles on the response path.
- Minimum burst-to-burst gap: 1 cycle in ARB_IDLE.
- Simultaneous new request and burst-end response: the new request is not granted until ARB_IDLE.
- Reset mid-burst: next cycle ARB_IDLE, counters 0, grant dropped. In-flight memory responses after reset count as unexpected only if they arrive after rst deasserts.

## Structure
- arb_state_t enum goes in the shared defines package alongside cache_state_t.
- Sub-module ama_riscv_rr_pick2: combinational 2-way round-robin pick (inputs: valids, rr_last; output: one-hot grant).
- The FSM, counters and steering muxes live in the top module.

## Test plan
- IC-only miss: req_ic addr 0x10..0x13 over 4 beats, memory returns D0..D3 -> rsp_ic receives D0..D3 in order; grant_ic high for the burst; rsp_dc.valid stays 0.
- Tie after reset: both valid in the same cycle (ic 0x20, dc 0x40) -> icache served first; dcache req.ready stays 0 until 1 idle cycle after the 4th icache response; dcache then gets its burst.
- Alternation: continuous requests from both, 3 bursts -> grant order IC, DC, IC.
- Backpressure: owner rsp.ready low for 2 cycles on beat 2 -> rsp_mem.ready low for those cycles; no beat is lost or duplicated; burst ends after beat 3 is accepted.
- Over-request: owner presents a 5th beat -> req.ready = 0 for it; it is forwarded only in the next granted burst.
- Reset mid-burst after 2 responses -> next cycle ARB_IDLE with grants 0; a response injected afterwards sets err_unexp_rsp.

Source files
------------

// File: rtl/ama_riscv_mem_arbiter_pkg.sv
// Shared memory-subsystem defines: bus geometry and the cache / arbiter state types.
package ama_riscv_mem_arbiter_pkg;

   localparam int MEM_ADDR_BUS         = 32;
   localparam int MEM_DATA_BUS         = 128;
   localparam int MEM_TRANSFERS_PER_CL = 4;

   typedef enum logic [1:0] {
      CACHE_RESET = 2'd0,
      CACHE_READY = 2'd1,
      CACHE_MISS  = 2'd2
   } cache_state_t;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_IC   = 2'd1,
      ARB_DC   = 2'd2
   } arb_state_t;

   // Encoding of the requester that owned the previous burst
   localparam logic RR_IC = 1'b0;
   localparam logic RR_DC = 1'b1;

endpackage

// File: rtl/ama_riscv_mem_arbiter_rr_pick2.sv
// Two-way round-robin pick between the icache and dcache line-fill requests.
// grant[0] selects the icache, grant[1] the dcache.
module ama_riscv_rr_pick2
   import ama_riscv_mem_arbiter_pkg::*;
(
   input  logic       valid_ic,
   input  logic       valid_dc,
   input  logic       rr_last,
   output logic [1:0] grant
);

   // lone requester wins; on a tie the one not served last wins
   always_comb begin
      grant = 2'b00;
      case ({valid_dc, valid_ic})
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = (rr_last == RR_DC) ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/ama_riscv_mem_arbiter.sv
// Shares the main-memory port between the icache and dcache fill engines, one
// full cache-line burst per grant, with responses steered back to the owner only.
module ama_riscv_mem_arbiter
   import ama_riscv_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = MEM_ADDR_BUS,
   parameter int DATA_W = MEM_DATA_BUS,
   parameter int BEATS  = MEM_TRANSFERS_PER_CL
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              req_ic_valid,
   output logic              req_ic_ready,
   input  logic [ADDR_W-1:0] req_ic_data,
   output logic              rsp_ic_valid,
   input  logic              rsp_ic_ready,
   output logic [DATA_W-1:0] rsp_ic_data,
   input  logic              req_dc_valid,
   output logic              req_dc_ready,
   input  logic [ADDR_W-1:0] req_dc_data,
   output logic              rsp_dc_valid,
   input  logic              rsp_dc_ready,
   output logic [DATA_W-1:0] rsp_dc_data,
   output logic              req_mem_valid,
   input  logic              req_mem_ready,
   output logic [ADDR_W-1:0] req_mem_data,
   input  logic              rsp_mem_valid,
   output logic              rsp_mem_ready,
   input  logic [DATA_W-1:0] rsp_mem_data,
   output logic              grant_ic,
   output logic              grant_dc,
   output logic              err_unexp_rsp
);

   localparam int               CNT_W   = $clog2(BEATS) + 1;
   localparam logic [CNT_W-1:0] BEATS_C = CNT_W'(BEATS);
   localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(BEATS - 1);

   arb_state_t       state_r;
   logic             rr_last_r;
   logic [CNT_W-1:0] req_cnt_r;
   logic [CNT_W-1:0] rsp_cnt_r;
   logic             grant_ic_r;
   logic             grant_dc_r;
   logic             err_unexp_r;

   logic [1:0]       pick_s;
   logic             own_ic_s;
   logic             own_dc_s;
   logic             req_room_s;
   logic             req_fire_s;
   logic             unexp_s;
   logic             rsp_fire_s;
   logic             burst_end_s;

   ama_riscv_rr_pick2 u_pick (
      .valid_ic (req_ic_valid),
      .valid_dc (req_dc_valid),
      .rr_last  (rr_last_r),
      .grant    (pick_s)
   );

   // request-path owner: the registered owner, or the idle-cycle winner so its first beat goes out immediately
   always_comb begin
      own_ic_s = 1'b0;
      own_dc_s = 1'b0;
      case (state_r)
         ARB_IDLE: begin
            own_ic_s = pick_s[0];
            own_dc_s = pick_s[1];
         end
         ARB_IC:  own_ic_s = 1'b1;
         ARB_DC:  own_dc_s = 1'b1;
         default: begin
            own_ic_s = 1'b0;
            own_dc_s = 1'b0;
         end
      endcase
   end

   // request steering; beats beyond one line are held off until the next grant
   always_comb begin
      req_room_s    = (req_cnt_r < BEATS_C);
      req_mem_valid = 1'b0;
      req_mem_data  = {ADDR_W{1'b0}};
      req_ic_ready  = 1'b0;
      req_dc_ready  = 1'b0;
      if (own_ic_s) begin
         req_mem_valid = req_ic_valid && req_room_s;
         req_mem_data  = req_ic_data;
         req_ic_ready  = req_mem_ready && req_room_s;
      end else if (own_dc_s) begin
         req_mem_valid = req_dc_valid && req_room_s;
         req_mem_data  = req_dc_data;
         req_dc_ready  = req_mem_ready && req_room_s;
      end else begin
         req_mem_valid = 1'b0;
      end
      req_fire_s = req_mem_valid && req_mem_ready;
   end

   // response steering; a response with nothing outstanding is drained and dropped
   always_comb begin
      unexp_s       = rsp_mem_valid && ((state_r == ARB_IDLE) || (rsp_cnt_r == req_cnt_r));
      rsp_mem_ready = 1'b0;
      rsp_ic_valid  = 1'b0;
      rsp_ic_data   = {DATA_W{1'b0}};
      rsp_dc_valid  = 1'b0;
      rsp_dc_data   = {DATA_W{1'b0}};
      if (unexp_s) begin
         rsp_mem_ready = 1'b1;
      end else if (state_r == ARB_IC) begin
         rsp_ic_valid  = rsp_mem_valid;
         rsp_ic_data   = rsp_mem_data;
         rsp_mem_ready = rsp_ic_ready;
      end else if (state_r == ARB_DC) begin
         rsp_dc_valid  = rsp_mem_valid;
         rsp_dc_data   = rsp_mem_data;
         rsp_mem_ready = rsp_dc_ready;
      end else begin
         rsp_mem_ready = 1'b0;
      end
      rsp_fire_s  = rsp_mem_valid && rsp_mem_ready && !unexp_s;
      burst_end_s = rsp_fire_s && (rsp_cnt_r == LAST_C);
   end

   // arbitration FSM, beat counters, grant and error flags
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ARB_IDLE;
         rr_last_r   <= RR_DC;
         req_cnt_r   <= {CNT_W{1'b0}};
         rsp_cnt_r   <= {CNT_W{1'b0}};
         grant_ic_r  <= 1'b0;
         grant_dc_r  <= 1'b0;
         err_unexp_r <= 1'b0;
      end else begin
         if (unexp_s) begin
            err_unexp_r <= 1'b1;
         end
         case (state_r)
            ARB_IDLE: begin
               if (pick_s[0]) begin
                  state_r    <= ARB_IC;
                  rr_last_r  <= RR_IC;
                  grant_ic_r <= 1'b1;
               end else if (pick_s[1]) begin
                  state_r    <= ARB_DC;
                  rr_last_r  <= RR_DC;
                  grant_dc_r <= 1'b1;
               end
               req_cnt_r <= CNT_W'(req_fire_s);
               rsp_cnt_r <= {CNT_W{1'b0}};
            end
            ARB_IC, ARB_DC: begin
               if (burst_end_s) begin
                  state_r    <= ARB_IDLE;
                  req_cnt_r  <= {CNT_W{1'b0}};
                  rsp_cnt_r  <= {CNT_W{1'b0}};
                  grant_ic_r <= 1'b0;
                  grant_dc_r <= 1'b0;
               end else begin
                  req_cnt_r <= req_cnt_r + CNT_W'(req_fire_s);
                  rsp_cnt_r <= rsp_cnt_r + CNT_W'(rsp_fire_s);
               end
            end
            default: begin
               state_r    <= ARB_IDLE;
               req_cnt_r  <= {CNT_W{1'b0}};
               rsp_cnt_r  <= {CNT_W{1'b0}};
               grant_ic_r <= 1'b0;
               grant_dc_r <= 1'b0;
            end
         endcase
      end
   end

   assign grant_ic      = grant_ic_r;
   assign grant_dc      = grant_dc_r;
   assign err_unexp_rsp = err_unexp_r;

endmodule

// File: tb/tb_ama_riscv_mem_arbiter.sv
// Scoreboard bench for ama_riscv_mem_arbiter: requester sources, a 1-cycle
// latency memory model, and per-scenario checks of grant order and steering.
module tb_ama_riscv_mem_arbiter;
   import ama_riscv_mem_arbiter_pkg::*;

   localparam int ADDR_W = MEM_ADDR_BUS;
   localparam int DATA_W = MEM_DATA_BUS;
   localparam int BEATS  = MEM_TRANSFERS_PER_CL;

   logic              clk, rst;
   logic              req_ic_valid, req_ic_ready, rsp_ic_valid, rsp_ic_ready;
   logic              req_dc_valid, req_dc_ready, rsp_dc_valid, rsp_dc_ready;
   logic              req_mem_valid, req_mem_ready, rsp_mem_valid, rsp_mem_ready;
   logic [ADDR_W-1:0] req_ic_data, req_dc_data, req_mem_data;
   logic [DATA_W-1:0] rsp_ic_data, rsp_dc_data, rsp_mem_data;
   logic              grant_ic, grant_dc, err_unexp_rsp;

   ama_riscv_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS)) dut (
      .clk(clk), .rst(rst),
      .req_ic_valid(req_ic_valid), .req_ic_ready(req_ic_ready), .req_ic_data(req_ic_data),
      .rsp_ic_valid(rsp_ic_valid), .rsp_ic_ready(rsp_ic_ready), .rsp_ic_data(rsp_ic_data),
      .req_dc_valid(req_dc_valid), .req_dc_ready(req_dc_ready), .req_dc_data(req_dc_data),
      .rsp_dc_valid(rsp_dc_valid), .rsp_dc_ready(rsp_dc_ready), .rsp_dc_data(rsp_dc_data),
      .req_mem_valid(req_mem_valid), .req_mem_ready(req_mem_ready), .req_mem_data(req_mem_data),
      .rsp_mem_valid(rsp_mem_valid), .rsp_mem_ready(rsp_mem_ready), .rsp_mem_data(rsp_mem_data),
      .grant_ic(grant_ic), .grant_dc(grant_dc), .err_unexp_rsp(err_unexp_rsp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   logic [ADDR_W-1:0] ic_src[$], dc_src[$], mem_pend[$];
   logic [DATA_W-1:0] exp_ic[$], exp_dc[$];
   int                grant_log[$];

   int ic_rcv, dc_rcv, leak, gic_cycles, last_ic_rsp_cyc, first_dc_rdy_cyc;
   int bp_beat, bp_left, stall_cycles, held_cycles, idle_after_cyc, addr_fire_cyc;
   logic [ADDR_W-1:0] watch_addr;
   logic prev_gic = 1'b0, prev_gdc = 1'b0;

   logic              s_gic, s_gdc, s_err, s_req_mem_valid, s_rsp_mem_ready;
   logic              s_rsp_ic_valid, s_rsp_dc_valid, s_req_ic_ready, s_req_dc_ready;
   logic [ADDR_W-1:0] s_req_mem_data;
   logic [DATA_W-1:0] s_rsp_ic_data, s_rsp_dc_data;

   function automatic logic [DATA_W-1:0] mem_data(input logic [ADDR_W-1:0] a);
      return {a ^ 32'hDEAD_BEEF, ~a, a, a ^ 32'hC0DE_0000};
   endfunction

   function automatic int glog_code();
      int c = 0;
      foreach (grant_log[i]) c = c * 10 + grant_log[i] + 1;
      return c;
   endfunction

   task automatic clear();
      ic_src.delete(); dc_src.delete(); exp_ic.delete(); exp_dc.delete(); grant_log.delete();
      ic_rcv = 0; dc_rcv = 0; leak = 0; gic_cycles = 0; last_ic_rsp_cyc = -1; first_dc_rdy_cyc = -1;
      bp_beat = 0; bp_left = 0; stall_cycles = 0; held_cycles = 0; idle_after_cyc = -1;
      addr_fire_cyc = -1; watch_addr = {ADDR_W{1'b1}};
   endtask

   task automatic drive();
      req_ic_valid  = (ic_src.size() > 0);
      req_ic_data   = req_ic_valid ? ic_src[0] : {ADDR_W{1'b0}};
      req_dc_valid  = (dc_src.size() > 0);
      req_dc_data   = req_dc_valid ? dc_src[0] : {ADDR_W{1'b0}};
      rsp_mem_valid = (mem_pend.size() > 0);
      rsp_mem_data  = rsp_mem_valid ? mem_data(mem_pend[0]) : {DATA_W{1'b0}};
      rsp_ic_ready  = !(bp_left > 0 && ic_rcv == bp_beat);
      rsp_dc_ready  = 1'b1;
      req_mem_ready = 1'b1;
   endtask

   // one clock: sample at negedge, score responses, update models, advance to posedge+1
   task automatic step();
      logic ic_fire, dc_fire;
      logic [DATA_W-1:0] e;
      #4;
      s_gic = grant_ic; s_gdc = grant_dc; s_err = err_unexp_rsp;
      s_req_mem_valid = req_mem_valid; s_req_mem_data = req_mem_data; s_rsp_mem_ready = rsp_mem_ready;
      s_rsp_ic_valid = rsp_ic_valid; s_rsp_dc_valid = rsp_dc_valid;
      s_rsp_ic_data = rsp_ic_data; s_rsp_dc_data = rsp_dc_data;
      s_req_ic_ready = req_ic_ready; s_req_dc_ready = req_dc_ready;
      ic_fire = req_ic_valid && req_ic_ready;
      dc_fire = req_dc_valid && req_dc_ready;
      if (rsp_ic_valid === 1'b1 && rsp_ic_ready) begin
         n_cmp++;
         if (exp_ic.size() == 0) begin
            n_err++; $display("FAIL sb_ic: got %h, required no response", rsp_ic_data);
         end else begin
            e = exp_ic.pop_front();
            if (rsp_ic_data !== e) begin n_err++; $display("FAIL sb_ic: got %h, required %h", rsp_ic_data, e); end
         end
         ic_rcv++; last_ic_rsp_cyc = cyc;
      end
      if (rsp_dc_valid === 1'b1 && rsp_dc_ready) begin
         n_cmp++;
         if (exp_dc.size() == 0) begin
            n_err++; $display("FAIL sb_dc: got %h, required no response", rsp_dc_data);
         end else begin
            e = exp_dc.pop_front();
            if (rsp_dc_data !== e) begin n_err++; $display("FAIL sb_dc: got %h, required %h", rsp_dc_data, e); end
         end
         dc_rcv++;
      end
      if (rsp_ic_valid === 1'b1 && !rsp_ic_ready) begin
         bp_left--;
         if (rsp_mem_ready === 1'b0) stall_cycles++;
      end
      if ((grant_ic === 1'b1 && rsp_dc_valid !== 1'b0) || (grant_dc === 1'b1 && rsp_ic_valid !== 1'b0)) leak++;
      if (grant_ic === 1'b1) gic_cycles++;
      if (req_dc_ready === 1'b1 && first_dc_rdy_cyc < 0) first_dc_rdy_cyc = cyc;
      if (grant_ic === 1'b1 && req_ic_valid && req_ic_ready === 1'b0 && req_mem_ready) held_cycles++;
      if (grant_ic === 1'b0 && grant_dc === 1'b0 && (prev_gic || prev_gdc) && idle_after_cyc < 0)
         idle_after_cyc = cyc;
      if (grant_ic === 1'b1 && !prev_gic) grant_log.push_back(0);
      if (grant_dc === 1'b1 && !prev_gdc) grant_log.push_back(1);
      prev_gic = (grant_ic === 1'b1);
      prev_gdc = (grant_dc === 1'b1);
      if (rsp_mem_valid && rsp_mem_ready === 1'b1 && mem_pend.size() > 0) void'(mem_pend.pop_front());
      if (req_mem_valid === 1'b1 && req_mem_ready) begin
         mem_pend.push_back(req_mem_data);
         if (req_mem_data == watch_addr) addr_fire_cyc = cyc;
      end
      if (ic_fire === 1'b1) begin exp_ic.push_back(mem_data(ic_src[0])); void'(ic_src.pop_front()); end
      if (dc_fire === 1'b1) begin exp_dc.push_back(mem_data(dc_src[0])); void'(dc_src.pop_front()); end
      @(posedge clk); #1;
      cyc++;
      drive();
   endtask

   task automatic run(input int budget, input string name);
      int n = 0;
      while (n < budget && !(ic_src.size() == 0 && dc_src.size() == 0 && mem_pend.size() == 0 &&
                              exp_ic.size() == 0 && exp_dc.size() == 0 && n > 0 && !s_gic && !s_gdc)) begin
         step(); n++;
      end
      n_cmp++;
      if (n >= budget) begin n_err++; $display("FAIL %s_timeout: ran %0d cycles, required completion", name, n); end
   endtask

   task automatic do_reset();
      rst = 1'b1; drive(); step(); rst = 1'b0;
   endtask

   task automatic test_reset();
      clear();
      rst = 1'b1; drive(); step(); step(); rst = 1'b0;
      n_cmp++; if ({s_gic, s_gdc} !== 2'b00) begin n_err++; $display("FAIL rst_grant: got %b, required 00", {s_gic, s_gdc}); end
      n_cmp++; if (s_err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b, required 0", s_err); end
      n_cmp++; if ({s_req_mem_valid, s_rsp_mem_ready, s_rsp_ic_valid, s_rsp_dc_valid, s_req_ic_ready, s_req_dc_ready} !== 6'b0)
         begin n_err++; $display("FAIL rst_handshake: got %b, required 000000",
            {s_req_mem_valid, s_rsp_mem_ready, s_rsp_ic_valid, s_rsp_dc_valid, s_req_ic_ready, s_req_dc_ready}); end
      n_cmp++; if (s_req_mem_data !== {ADDR_W{1'b0}} || s_rsp_ic_data !== {DATA_W{1'b0}} || s_rsp_dc_data !== {DATA_W{1'b0}})
         begin n_err++; $display("FAIL rst_data: got %h/%h/%h, required zeros", s_req_mem_data, s_rsp_ic_data, s_rsp_dc_data); end
   endtask

   task automatic test_ic_only();
      clear();
      for (int i = 0; i < 4; i++) ic_src.push_back(32'h10 + 32'(i));
      run(60, "ic_only");
      n_cmp++; if (ic_rcv != 4) begin n_err++; $display("FAIL ic_only_count: got %0d, required 4", ic_rcv); end
      n_cmp++; if (glog_code() != 1) begin n_err++; $display("FAIL ic_only_grants: got %0d, required 1", glog_code()); end
      n_cmp++; if (gic_cycles != 4) begin n_err++; $display("FAIL ic_only_grant_len: got %0d, required 4", gic_cycles); end
      n_cmp++; if (leak != 0 || dc_rcv != 0) begin n_err++; $display("FAIL ic_only_dc_quiet: got leak %0d dc %0d, required 0 0", leak, dc_rcv); end
   endtask

   task automatic test_tie();
      clear();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         ic_src.push_back(32'h20 + 32'(i));
         dc_src.push_back(32'h40 + 32'(i));
      end
      drive();
      run(80, "tie");
      n_cmp++; if (glog_code() != 12) begin n_err++; $display("FAIL tie_order: got %0d, required 12", glog_code()); end
      n_cmp++; if (first_dc_rdy_cyc != last_ic_rsp_cyc + 1)
         begin n_err++; $display("FAIL tie_dc_ready: got cycle %0d, required %0d", first_dc_rdy_cyc, last_ic_rsp_cyc + 1); end
      n_cmp++; if (ic_rcv != 4 || dc_rcv != 4 || leak != 0)
         begin n_err++; $display("FAIL tie_counts: got ic %0d dc %0d leak %0d, required 4 4 0", ic_rcv, dc_rcv, leak); end
   endtask

   task automatic test_alternation();
      clear();
      for (int i = 0; i < 8; i++) ic_src.push_back(32'h100 + 32'(i));
      for (int i = 0; i < 4; i++) dc_src.push_back(32'h200 + 32'(i));
      drive();
      run(120, "alt");
      n_cmp++; if (glog_code() != 121) begin n_err++; $display("FAIL alt_order: got %0d, required 121", glog_code()); end
      n_cmp++; if (ic_rcv != 8 || dc_rcv != 4) begin n_err++; $display("FAIL alt_counts: got ic %0d dc %0d, required 8 4", ic_rcv, dc_rcv); end
      n_cmp++; if (s_err !== 1'b0) begin n_err++; $display("FAIL alt_err: got %b, required 0", s_err); end
   endtask

   task automatic test_backpressure();
      clear();
      bp_beat = 2; bp_left = 2;
      for (int i = 0; i < 4; i++) ic_src.push_back(32'h30 + 32'(i));
      drive();
      run(60, "bp");
      n_cmp++; if (stall_cycles != 2) begin n_err++; $display("FAIL bp_mem_ready_low: got %0d cycles, required 2", stall_cycles); end
      n_cmp++; if (ic_rcv != 4) begin n_err++; $display("FAIL bp_count: got %0d, required 4", ic_rcv); end
      n_cmp++; if (gic_cycles != 6) begin n_err++; $display("FAIL bp_burst_len: got %0d, required 6", gic_cycles); end
   endtask

   task automatic test_over_request();
      clear();
      watch_addr = 32'h304;
      for (int i = 0; i < 8; i++) ic_src.push_back(32'h300 + 32'(i));
      drive();
      run(120, "over");
      n_cmp++; if (held_cycles != 1) begin n_err++; $display("FAIL over_held: got %0d, required 1", held_cycles); end
      n_cmp++; if (addr_fire_cyc != idle_after_cyc || addr_fire_cyc < 0)
         begin n_err++; $display("FAIL over_5th_beat: got cycle %0d, required %0d", addr_fire_cyc, idle_after_cyc); end
      n_cmp++; if (glog_code() != 11 || ic_rcv != 8)
         begin n_err++; $display("FAIL over_bursts: got grants %0d rcv %0d, required 11 8", glog_code(), ic_rcv); end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      clear();
      for (int i = 0; i < 4; i++) ic_src.push_back(32'h50 + 32'(i));
      drive();
      while (ic_rcv < 2 && n < 20) begin step(); n++; end
      n_cmp++; if (ic_rcv != 2) begin n_err++; $display("FAIL mid_setup: got %0d responses, required 2", ic_rcv); end
      rst = 1'b1;
      ic_src.delete(); exp_ic.delete(); mem_pend.delete();
      drive();
      step();
      rst = 1'b0;
      step();
      n_cmp++; if ({s_gic, s_gdc, s_err} !== 3'b000) begin n_err++; $display("FAIL mid_idle: got grants/err %b, required 000", {s_gic, s_gdc, s_err}); end
      mem_pend.push_back(32'hBAD);
      drive();
      step();
      n_cmp++; if (s_rsp_mem_ready !== 1'b1 || s_rsp_ic_valid !== 1'b0)
         begin n_err++; $display("FAIL mid_drain: got ready %b ic_valid %b, required 1 0", s_rsp_mem_ready, s_rsp_ic_valid); end
      step();
      n_cmp++; if (s_err !== 1'b1) begin n_err++; $display("FAIL mid_err: got %b, required 1", s_err); end
   endtask

   initial begin
      rst = 1'b1;
      clear();
      drive();
      @(posedge clk); #1;
      test_reset();
      test_ic_only();
      test_tie();
      test_alternation();
      test_backpressure();
      test_over_request();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

endmodule
